// File: rtl/array_serializer.sv
// Array-to-scalar serializer: takes a whole N_ELEM array over a sync/notify in-port,
// then emits the elements forward or reversed, plus an optional wrap-around sum beat.
module array_serializer #(
  parameter  int N_ELEM = 5,
  parameter  int DATA_W = 32,
  parameter  int SUM_EN = 1,
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ELEM*DATA_W-1:0] b_in,
  input  logic                     b_in_rev,
  input  logic                     b_in_sync,
  output logic                     b_in_notify,
  output logic [DATA_W-1:0]        b_out,
  output logic [IDX_W-1:0]         b_out_idx,
  output logic                     b_out_is_sum,
  output logic                     b_out_last,
  input  logic                     b_out_sync,
  output logic                     b_out_notify
);

  localparam int NBEAT = N_ELEM + ((SUM_EN != 0) ? 1 : 0);
  localparam int CNT_W = $clog2(NBEAT + 1);

  typedef enum logic {RX, TX} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_buf [N_ELEM];
  logic [DATA_W-1:0]  r_sum;
  logic               r_rev;
  logic [CNT_W-1:0]   r_beat;

  logic [DATA_W-1:0]  w_sum;
  logic [DATA_W-1:0]  w_first;
  logic [IDX_W-1:0]   w_first_idx;
  int                 w_first_int;
  int                 w_nxt_int;
  int                 w_nxt_src;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic               w_nxt_is_sum;
  logic               w_nxt_last;

  // Unsigned add gives the two's-complement wrap-around sum directly.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_ELEM; i++)
      w_sum = w_sum + b_in[i*DATA_W +: DATA_W];
  end

  always_comb begin
    w_first_int  = b_in_rev ? (N_ELEM - 1) : 0;
    w_first_idx  = IDX_W'(w_first_int);
    w_first      = b_in[w_first_int*DATA_W +: DATA_W];
    w_nxt_int    = int'(r_beat) + 1;
    w_nxt_src    = r_rev ? (N_ELEM - 1 - w_nxt_int) : w_nxt_int;
    w_nxt_is_sum = (SUM_EN != 0) && (w_nxt_int == N_ELEM);
    w_nxt_idx    = w_nxt_is_sum ? '0 : IDX_W'(w_nxt_src);
    w_nxt_last   = (w_nxt_int == NBEAT - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= RX;
      for (int i = 0; i < N_ELEM; i++) r_buf[i] <= '0;
      r_sum        <= '0;
      r_rev        <= 1'b0;
      r_beat       <= '0;
      b_in_notify  <= 1'b1;
      b_out_notify <= 1'b0;
      b_out        <= '0;
      b_out_idx    <= '0;
      b_out_is_sum <= 1'b0;
      b_out_last   <= 1'b0;
    end else begin
      case (r_state)
        RX: if (b_in_notify && b_in_sync) begin
          for (int i = 0; i < N_ELEM; i++) r_buf[i] <= b_in[i*DATA_W +: DATA_W];
          r_rev        <= b_in_rev;
          r_sum        <= w_sum;
          r_beat       <= '0;
          b_out        <= w_first;
          b_out_idx    <= w_first_idx;
          b_out_is_sum <= 1'b0;
          b_out_last   <= 1'b0;
          b_in_notify  <= 1'b0;
          b_out_notify <= 1'b1;
          r_state      <= TX;
        end
        TX: if (b_out_notify && b_out_sync) begin
          if (b_out_last) begin
            // b_out keeps the final value; only the flags drop.
            r_beat       <= '0;
            b_out_idx    <= '0;
            b_out_is_sum <= 1'b0;
            b_out_last   <= 1'b0;
            b_out_notify <= 1'b0;
            b_in_notify  <= 1'b1;
            r_state      <= RX;
          end else begin
            r_beat       <= CNT_W'(w_nxt_int);
            b_out        <= w_nxt_is_sum ? r_sum : r_buf[w_nxt_idx];
            b_out_idx    <= w_nxt_idx;
            b_out_is_sum <= w_nxt_is_sum;
            b_out_last   <= w_nxt_last;
          end
        end
        default: r_state <= RX;
      endcase
    end
  end

endmodule

// File: tb/tb_array_serializer.sv
// Scoreboard bench for array_serializer (N_ELEM=5, DATA_W=32, SUM_EN=1): stimulus pushes
// expected beats, a negedge monitor drives b_out_sync and pops/compares on each out-transfer.
module tb_array_serializer;
  localparam int N = 5;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   idx;
    logic         s;
    logic         l;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] b_in = '0;
  logic           b_in_rev = 1'b0;
  logic           b_in_sync = 1'b0;
  logic           b_in_notify;
  logic [W-1:0]   b_out;
  logic [2:0]     b_out_idx;
  logic           b_out_is_sum;
  logic           b_out_last;
  logic           b_out_sync = 1'b0;
  logic           b_out_notify;

  array_serializer #(.N_ELEM(N), .DATA_W(W), .SUM_EN(1)) dut (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_rev(b_in_rev), .b_in_sync(b_in_sync), .b_in_notify(b_in_notify),
    .b_out(b_out), .b_out_idx(b_out_idx), .b_out_is_sum(b_out_is_sum),
    .b_out_last(b_out_last), .b_out_sync(b_out_sync), .b_out_notify(b_out_notify)
  );

  always #5 clk = ~clk;

  int    vec = 0;
  int    bad = 0;
  beat_t q[$];
  int    mode = 1;        // 0: never take, 1: always take, 2: take 1,0,0 pattern
  int    budget = 1000000;
  int    cyc = 0;
  logic  chk_idle = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t held;

  // Monitor: runs on negedge, decides b_out_sync for the next posedge and checks beats.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_idle) begin
        vec++;
        if (!(b_in_notify && !b_out_notify && !b_out_is_sum && !b_out_last)) begin
          bad++;
          $display("FAIL after_last: in_notify=%0b out_notify=%0b sum=%0b last=%0b, required 1 0 0 0",
                   b_in_notify, b_out_notify, b_out_is_sum, b_out_last);
        end
        chk_idle = 1'b0;
      end
      if (prev_stall && b_out_notify) begin
        vec++;
        if (b_out !== held.d || b_out_idx !== held.idx || b_out_is_sum !== held.s || b_out_last !== held.l) begin
          bad++;
          $display("FAIL stall_hold: got d=%h idx=%0d s=%0b l=%0b, required d=%h idx=%0d s=%0b l=%0b",
                   b_out, b_out_idx, b_out_is_sum, b_out_last, held.d, held.idx, held.s, held.l);
        end
      end
      prev_stall = 1'b0;
      b_out_sync = (budget > 0) && (mode == 1 || (mode == 2 && (cyc % 3) == 0));
      if (b_out_notify && b_out_sync) begin
        vec++;
        budget--;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h idx=%0d, required no beat", b_out, b_out_idx);
        end else begin
          e = q.pop_front();
          if (b_out !== e.d || b_out_idx !== e.idx || b_out_is_sum !== e.s ||
              b_out_last !== e.l || b_in_notify !== 1'b0) begin
            bad++;
            $display("FAIL beat: got d=%h idx=%0d s=%0b l=%0b in_notify=%0b, required d=%h idx=%0d s=%0b l=%0b in_notify=0",
                     b_out, b_out_idx, b_out_is_sum, b_out_last, b_in_notify, e.d, e.idx, e.s, e.l);
          end
          if (e.l) chk_idle = 1'b1;
        end
      end else if (b_out_notify) begin
        prev_stall = 1'b1;
        held.d = b_out; held.idx = b_out_idx; held.s = b_out_is_sum; held.l = b_out_last;
      end
    end
  end

  task automatic check_idle(input string name, input logic [W-1:0] exp_d);
    vec++;
    if (b_in_notify !== 1'b1 || b_out_notify !== 1'b0 || b_out !== exp_d ||
        b_out_idx !== 3'd0 || b_out_is_sum !== 1'b0 || b_out_last !== 1'b0) begin
      bad++;
      $display("FAIL %s: in_notify=%0b out_notify=%0b d=%h idx=%0d s=%0b l=%0b, required 1 0 %h 0 0 0",
               name, b_in_notify, b_out_notify, b_out, b_out_idx, b_out_is_sum, b_out_last, exp_d);
    end
  endtask

  // Offer one array; expected beats come from the hand-listed elements and hand-computed sum.
  task automatic send(input logic [W-1:0] e0, e1, e2, e3, e4, input logic rev, input logic [W-1:0] sum);
    logic [W-1:0] el [N];
    beat_t b;
    int t;
    el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3; el[4] = e4;
    t = 0;
    @(negedge clk);
    while (!b_in_notify && t < 200) begin @(negedge clk); t++; end
    if (!b_in_notify) begin
      vec++; bad++;
      $display("FAIL in_notify_timeout: got 0, required 1");
    end
    for (int k = 0; k < N; k++) begin
      b.idx = rev ? 3'(N - 1 - k) : 3'(k);
      b.d = el[b.idx]; b.s = 1'b0; b.l = 1'b0;
      q.push_back(b);
    end
    b.d = sum; b.idx = 3'd0; b.s = 1'b1; b.l = 1'b1;
    q.push_back(b);
    b_in = {e4, e3, e2, e1, e0};
    b_in_rev = rev;
    b_in_sync = 1'b1;
    @(negedge clk);
    b_in_sync = 1'b0;
    b_in = {5{32'hDEAD_BEEF}};
    b_in_rev = ~rev;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (q.size() != 0) begin
      vec++; bad++;
      $display("FAIL %s_drain_timeout: got %0d beats pending, required 0", name, q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    // 1: reset, then idle with b_in_sync held low
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_idle("reset_idle", 32'h0);
    end

    // 2: forward order
    mode = 1;
    send(1, 2, 3, 4, 5, 1'b0, 32'd15);
    drain("fwd");
    // 3: reverse order
    send(1, 2, 3, 4, 5, 1'b1, 32'd15);
    drain("rev");
    // 4: stalled consumer, signed elements (10-3+7+100-20 = 94)
    mode = 2;
    send(32'd10, -32'sd3, 32'd7, 32'd100, -32'sd20, 1'b0, 32'd94);
    drain("stall_fwd");
    send(32'd10, -32'sd3, 32'd7, 32'd100, -32'sd20, 1'b1, 32'd94);
    drain("stall_rev");
    // 5: sum wraps
    mode = 1;
    send(32'h7FFF_FFFF, 1, 0, 0, 0, 1'b0, 32'h8000_0000);
    drain("wrap");
    // back-to-back arrays with both partners always ready
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0, 1'b1, 32'h0);
    send(6, 7, 8, 9, 10, 1'b0, 32'd40);
    drain("b2b");

    // 6: reset after two out-beats
    budget = 2;
    send(1, 2, 3, 4, 5, 1'b0, 32'd15);
    t = 0;
    while (budget > 0 && t < 200) begin @(negedge clk); t++; end
    if (budget > 0) begin
      vec++; bad++;
      $display("FAIL midtx_timeout: got %0d beats left, required 0", budget);
    end
    @(negedge clk);
    vec++;
    if (b_out_notify !== 1'b1 || b_out !== 32'd3) begin
      bad++;
      $display("FAIL midtx_hold: got notify=%0b d=%h, required 1 00000003", b_out_notify, b_out);
    end
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    check_idle("midtx_reset", 32'h0);
    budget = 1000000;
    send(9, 9, 9, 9, 9, 1'b0, 32'd45);
    drain("after_reset");

    vec++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL final_queue: got %0d, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
